// File: rtl/arbitro_memoria.sv
// rtl/arbitro_memoria.sv - two-port data memory arbiter with a three-state access FSM
//
// Purpose: serialises accesses from port 0 (processor) and port 1 (DMA/loader)
// onto a single data memory. Each access takes three cycles:
//   OCIOSO (sample and latch the winner), ACESSO (strobe), RESPOSTA (Ack).
//
// Ports:
//   Clock, Reset            system clock, synchronous active-high reset
//   Req0/1, Escr0/1         request and access type (1 = write) per port
//   Endereco0/1, DadoEscr0/1  address and write data per port
//   Ack0/1                  one-cycle completion pulse to the granted port
//   DadoLido0/1             per-port registered read data
//   Endereco, DadoEscr      address / write data to the memory
//   MenWrite, MenRead       memory strobes, high only in ACESSO
//   DadoMem                 read data from the memory
//   Ocupado                 high whenever the FSM is not in OCIOSO
//
// Macro PRIORIDADE_FIXA_EN: when defined, port 0 always wins a tie;
// otherwise ties alternate (round-robin).
module arbitro_memoria #(
  parameter int LARG_END  = 8,
  parameter int LARG_DADO = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Req0,
  input  logic                 Req1,
  input  logic                 Escr0,
  input  logic                 Escr1,
  input  logic [LARG_END-1:0]  Endereco0,
  input  logic [LARG_END-1:0]  Endereco1,
  input  logic [LARG_DADO-1:0] DadoEscr0,
  input  logic [LARG_DADO-1:0] DadoEscr1,
  output logic                 Ack0,
  output logic                 Ack1,
  output logic [LARG_DADO-1:0] DadoLido0,
  output logic [LARG_DADO-1:0] DadoLido1,
  output logic [LARG_END-1:0]  Endereco,
  output logic [LARG_DADO-1:0] DadoEscr,
  output logic                 MenWrite,
  output logic                 MenRead,
  input  logic [LARG_DADO-1:0] DadoMem,
  output logic                 Ocupado
);

  typedef enum logic [1:0] {OCIOSO, ACESSO, RESPOSTA} estado_t;

  estado_t estado, proximo;
  logic    porta;     // port granted for the access in flight
  logic    escr;      // latched access type
  logic    ponteiro;  // port that wins when both request together
  logic    vencedor;  // winner of the current OCIOSO sample
  logic    concede;   // a grant happens at the end of this cycle

  assign concede = (estado == OCIOSO) && (Req0 || Req1);

  always_comb begin
    vencedor = 1'b0;
    if (Req0 && Req1) begin
      vencedor = ponteiro;
    end else if (Req1) begin
      vencedor = 1'b1;
    end
  end

`ifdef PRIORIDADE_FIXA_EN
  assign ponteiro = 1'b0;
`else
  // After every grant the tie goes to the port that just lost.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ponteiro <= 1'b0;
    end else if (concede) begin
      ponteiro <= ~vencedor;
    end
  end
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= proximo;
    end
  end

  // Strobes and Acks decode straight from the state register, so a reset
  // edge removes them immediately and abandons any access in flight.
  always_comb begin
    proximo  = estado;
    MenWrite = 1'b0;
    MenRead  = 1'b0;
    Ack0     = 1'b0;
    Ack1     = 1'b0;
    case (estado)
      OCIOSO: begin
        if (Req0 || Req1) begin
          proximo = ACESSO;
        end
      end
      ACESSO: begin
        proximo  = RESPOSTA;
        MenWrite = escr;
        MenRead  = ~escr;
      end
      RESPOSTA: begin
        proximo = OCIOSO;
        Ack0    = ~porta;
        Ack1    = porta;
      end
      default: proximo = OCIOSO;
    endcase
  end

  assign Ocupado = (estado != OCIOSO);

  // The request is captured once in OCIOSO; the requester may drop Req
  // afterwards without affecting the access.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      porta     <= 1'b0;
      escr      <= 1'b0;
      Endereco  <= '0;
      DadoEscr  <= '0;
      DadoLido0 <= '0;
      DadoLido1 <= '0;
    end else begin
      if (concede) begin
        porta    <= vencedor;
        escr     <= vencedor ? Escr1 : Escr0;
        Endereco <= vencedor ? Endereco1 : Endereco0;
        DadoEscr <= vencedor ? DadoEscr1 : DadoEscr0;
      end
      if ((estado == ACESSO) && !escr) begin
        if (porta) begin
          DadoLido1 <= DadoMem;
        end else begin
          DadoLido0 <= DadoMem;
        end
      end
    end
  end

endmodule

// File: tb/tb_arbitro_memoria.sv
// tb/tb_arbitro_memoria.sv - self-checking bench for arbitro_memoria
module tb_arbitro_memoria;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Req0 = 1'b0, Req1 = 1'b0, Escr0 = 1'b0, Escr1 = 1'b0;
  logic [7:0] Endereco0 = '0, Endereco1 = '0, DadoEscr0 = '0, DadoEscr1 = '0;
  logic       Ack0, Ack1, MenWrite, MenRead, Ocupado;
  logic [7:0] DadoLido0, DadoLido1, Endereco, DadoEscr, DadoMem;

  arbitro_memoria #(.LARG_END(8), .LARG_DADO(8)) dut (
    .Clock(Clock), .Reset(Reset),
    .Req0(Req0), .Req1(Req1), .Escr0(Escr0), .Escr1(Escr1),
    .Endereco0(Endereco0), .Endereco1(Endereco1),
    .DadoEscr0(DadoEscr0), .DadoEscr1(DadoEscr1),
    .Ack0(Ack0), .Ack1(Ack1), .DadoLido0(DadoLido0), .DadoLido1(DadoLido1),
    .Endereco(Endereco), .DadoEscr(DadoEscr),
    .MenWrite(MenWrite), .MenRead(MenRead), .DadoMem(DadoMem), .Ocupado(Ocupado)
  );

  always #5 Clock = ~Clock;

  // Data memory model: asynchronous read, write at the end of the strobe cycle.
  logic [7:0] mem [256] = '{default: 8'h00};
  assign DadoMem = mem[Endereco];
  always @(posedge Clock) if (MenWrite) mem[Endereco] <= DadoEscr;

  typedef struct {
    bit         port;
    bit         escr;
    logic [7:0] addr;
    logic [7:0] wdata;
    bit         chk_rd;
    logic [7:0] rd;
  } req_t;

  typedef struct {
    bit         p;
    bit         w;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] rd;
  } vec_t;

  req_t q0[$], q1[$];
  int   tests = 0, fails = 0;

  task automatic check(input string nome, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nome, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Monitor / scoreboard: records each strobe, and on each Ack pops the
  // granted port's oldest request and checks the strobe and read data.
  bit         st_prev = 1'b0;
  bit         st_escr;
  logic [7:0] st_addr, st_wdata, st_mem;
  logic [7:0] exp_lido0 = '0, exp_lido1 = '0;
  int         ack_count = 0, strobe_count = 0, cyc = 0;
  int         ack_log[$], ack_cyc[$];
  req_t       m_e;
  bit         m_p;

  always @(negedge Clock) begin
    cyc++;
    if (Reset) begin
      st_prev   = 1'b0;
      exp_lido0 = '0;
      exp_lido1 = '0;
    end else begin
      check("excl_strobe", MenWrite & MenRead, 0);
      check("excl_ack", Ack0 & Ack1, 0);
      if (MenWrite || MenRead) begin
        strobe_count++;
        check("strobe_owner", (q0.size() + q1.size()) != 0, 1);
        check("strobe_len", st_prev, 0);
        st_escr  = MenWrite;
        st_addr  = Endereco;
        st_wdata = DadoEscr;
        st_mem   = DadoMem;
      end
      if (Ack0 || Ack1) begin
        m_p = Ack1;
        ack_count++;
        ack_log.push_back(int'(m_p));
        ack_cyc.push_back(cyc);
        check("ack_after_strobe", st_prev, 1);
        if ((m_p && q1.size() == 0) || (!m_p && q0.size() == 0)) begin
          check("ack_has_request", 0, 1);
        end else begin
          m_e = m_p ? q1.pop_front() : q0.pop_front();
          check("ack_escr", st_escr, m_e.escr);
          check("ack_addr", st_addr, m_e.addr);
          if (m_e.escr) check("ack_wdata", st_wdata, m_e.wdata);
          else if (m_p) exp_lido1 = m_e.chk_rd ? m_e.rd : st_mem;
          else exp_lido0 = m_e.chk_rd ? m_e.rd : st_mem;
        end
        check("lido0", DadoLido0, exp_lido0);
        check("lido1", DadoLido1, exp_lido1);
      end
      st_prev = MenWrite | MenRead;
    end
  end

  function automatic vec_t mk(input bit p, input bit w, input logic [7:0] a,
                              input logic [7:0] d, input logic [7:0] rd);
    vec_t v;
    v.p = p; v.w = w; v.a = a; v.d = d; v.rd = rd;
    return v;
  endfunction

  task automatic set_port(input bit p, input bit w, input logic [7:0] a, input logic [7:0] d);
    if (p) begin Escr1 = w; Endereco1 = a; DadoEscr1 = d; end
    else   begin Escr0 = w; Endereco0 = a; DadoEscr0 = d; end
  endtask

  task automatic push_req(input bit p, input bit w, input logic [7:0] a,
                          input logic [7:0] d, input bit chk, input logic [7:0] rd);
    req_t e;
    e.port = p; e.escr = w; e.addr = a; e.wdata = d; e.chk_rd = chk; e.rd = rd;
    if (p) q1.push_back(e); else q0.push_back(e);
  endtask

  // Single access from idle with exact latency checks.
  task automatic acesso(input bit p, input bit w, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] rd);
    set_port(p, w, a, d);
    push_req(p, w, a, d, 1'b1, rd);
    if (p) Req1 = 1'b1; else Req0 = 1'b1;
    tick();
    check("lat_menwrite", MenWrite, w);
    check("lat_menread", MenRead, !w);
    check("lat_endereco", Endereco, a);
    if (w) check("lat_dadoescr", DadoEscr, d);
    tick();
    check("lat_ack_own", p ? Ack1 : Ack0, 1);
    check("lat_ack_other", p ? Ack0 : Ack1, 0);
    check("resp_strobes", MenWrite | MenRead, 0);
    if (!w) check("lat_lido", p ? DadoLido1 : DadoLido0, rd);
    Req0 = 1'b0;
    Req1 = 1'b0;
    tick();
    check("back_idle", Ocupado, 0);
  endtask

  task automatic requester(input bit p, input int n, output int feitos);
    req_t e;
    int   espera;
    feitos = 0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      e.escr  = 1'($urandom_range(0, 1));
      e.addr  = 8'($urandom_range(0, 15));
      e.wdata = 8'($urandom_range(0, 255));
      set_port(p, e.escr, e.addr, e.wdata);
      push_req(p, e.escr, e.addr, e.wdata, 1'b0, 8'h00);
      if (p) Req1 = 1'b1; else Req0 = 1'b1;
      espera = 0;
      do begin
        tick();
        espera++;
      end while (!(p ? Ack1 : Ack0) && espera < 60);
      if (p) Req1 = 1'b0; else Req0 = 1'b0;
      check(p ? "rand_wait_ack1" : "rand_wait_ack0", espera < 60, 1);
      if (espera >= 60) return;
      feitos++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab [11];
    int   s0, a0, n, n0, n1;
    int   exp_rr [4];

`ifdef PRIORIDADE_FIXA_EN
    exp_rr[0] = 0; exp_rr[1] = 0; exp_rr[2] = 0; exp_rr[3] = 0;
`else
    exp_rr[0] = 0; exp_rr[1] = 1; exp_rr[2] = 0; exp_rr[3] = 1;
`endif

    tab[0]  = mk(0, 1, 8'h10, 8'hA5, 8'h00);
    tab[1]  = mk(1, 1, 8'h20, 8'h3C, 8'h00);
    tab[2]  = mk(0, 0, 8'h20, 8'h00, 8'h3C);
    tab[3]  = mk(1, 0, 8'h10, 8'h00, 8'hA5);
    tab[4]  = mk(0, 1, 8'h20, 8'h77, 8'h00);
    tab[5]  = mk(1, 0, 8'h20, 8'h00, 8'h77);
    tab[6]  = mk(0, 0, 8'hFF, 8'h00, 8'h00);
    tab[7]  = mk(1, 1, 8'hFF, 8'hFF, 8'h00);
    tab[8]  = mk(0, 0, 8'hFF, 8'h00, 8'hFF);
    tab[9]  = mk(1, 1, 8'h00, 8'h5A, 8'h00);
    tab[10] = mk(1, 0, 8'h00, 8'h00, 8'h5A);

    repeat (3) tick();
    check("reset_outputs",
          {Ack0, Ack1, MenWrite, MenRead, Ocupado, Endereco, DadoEscr, DadoLido0, DadoLido1}, 0);
    Reset = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) acesso(tab[i].p, tab[i].w, tab[i].a, tab[i].d, tab[i].rd);

    // Req pulse that never reaches a sampling edge.
    s0 = strobe_count;
    set_port(1, 1'b1, 8'h40, 8'hEE);
    Req1 = 1'b1;
    #2;
    Req1 = 1'b0;
    repeat (4) tick();
    check("short_req_no_access", strobe_count - s0, 0);
    check("short_req_idle", Ocupado, 0);

    // Reset during ACESSO of a port 1 read.
    set_port(1, 1'b0, 8'h20, 8'h00);
    push_req(1, 1'b0, 8'h20, 8'h00, 1'b0, 8'h00);
    Req1 = 1'b1;
    tick();
    check("rst_acesso_menread", MenRead, 1);
    Reset = 1'b1;
    Req1  = 1'b0;
    a0    = ack_count;
    tick();
    check("rst_acesso_outputs",
          {Ack0, Ack1, MenWrite, MenRead, Ocupado, Endereco, DadoEscr, DadoLido0, DadoLido1}, 0);
    Reset = 1'b0;
    q1.delete();
    repeat (3) tick();
    check("rst_acesso_no_ack", ack_count - a0, 0);

    // Req dropped after it was latched still completes.
    set_port(0, 1'b0, 8'h10, 8'h00);
    push_req(0, 1'b0, 8'h10, 8'h00, 1'b1, 8'hA5);
    Req0 = 1'b1;
    tick();
    Req0 = 1'b0;
    check("drop_latched_menread", MenRead, 1);
    tick();
    check("drop_latched_ack0", Ack0, 1);
    tick();

    // Reset in idle clears read registers and the priority pointer.
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("rst_idle_lido0", DadoLido0, 0);

    // Both ports held high: grant order and spacing.
    set_port(0, 1'b0, 8'h20, 8'h00);
    set_port(1, 1'b0, 8'h10, 8'h00);
    for (int i = 0; i < 4; i++) begin
      push_req(0, 1'b0, 8'h20, 8'h00, 1'b0, 8'h00);
      push_req(1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00);
    end
    ack_log.delete();
    ack_cyc.delete();
    Req0 = 1'b1;
    Req1 = 1'b1;
    n = 0;
    for (int k = 0; k < 20 && n < 4; k++) begin
      tick();
      if (Ack0 || Ack1) n++;
    end
    Req0 = 1'b0;
    Req1 = 1'b0;
    tick();
    check("tie_ack_count", ack_log.size(), 4);
    for (int i = 0; i < ack_log.size() && i < 4; i++) check("tie_order", ack_log[i], exp_rr[i]);
    for (int i = 1; i < ack_cyc.size(); i++) check("tie_spacing", ack_cyc[i] - ack_cyc[i-1], 3);
    tick();
    q0.delete();
    q1.delete();
    tick();

    // Random mix from both ports.
    a0 = ack_count;
    fork
      requester(0, 260, n0);
      requester(1, 260, n1);
    join
    repeat (4) tick();
    check("rand_done", n0 + n1, 520);
    check("rand_acks", ack_count - a0, 520);
    check("rand_q_empty", q0.size() + q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/arbitro_memoria.md
ARBITRO_MEMORIA -- requirements
Module: arbitro_memoria

Interface
REQ-001 Parameter LARG_END, default 8, address width in bits.
REQ-002 Parameter LARG_DADO, default 8, data width in bits.
REQ-003 Clock  input  1  system clock; all state changes on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Req0 / Req1  input  1 each  access request from port 0 (processor) / port 1 (DMA/loader).
REQ-006 Escr0 / Escr1  input  1 each  access type: 1 = write, 0 = read.
REQ-007 Endereco0 / Endereco1  input  LARG_END each  requested address.
REQ-008 DadoEscr0 / DadoEscr1  input  LARG_DADO each  write data.
REQ-009 Ack0 / Ack1  output  1 each  one-cycle completion pulse to the granted port.
REQ-010 DadoLido0 / DadoLido1  output  LARG_DADO each  registered read data; valid while the matching Ack is high.
REQ-011 Endereco / DadoEscr  output  LARG_END / LARG_DADO  address and write data driven to the data memory.
REQ-012 MenWrite / MenRead  output  1 each  memory write / read strobes.
REQ-013 DadoMem  input  LARG_DADO  read data returned by the data memory.
REQ-014 Ocupado  output  1  high whenever the state is not OCIOSO.

Function
REQ-015 FSM states SHALL be OCIOSO, ACESSO, RESPOSTA; OCIOSO->ACESSO when any Req is high; ACESSO->RESPOSTA unconditionally; RESPOSTA->OCIOSO unconditionally.
REQ-016 In OCIOSO the arbiter SHALL sample the Req lines and latch the winning port's index, Escr, Endereco and DadoEscr.
REQ-017 In ACESSO, exactly one of MenWrite/MenRead SHALL be high for exactly one cycle, with Endereco/DadoEscr taken from the latched request.
REQ-018 For reads, DadoMem SHALL be registered at the end of ACESSO into the granted port's DadoLido register.
REQ-019 In RESPOSTA, only the granted port's Ack SHALL be high, for exactly one cycle; the other port's Ack and the memory strobes SHALL be low.
REQ-020 Latency: Req sampled high at edge k gives strobe during cycle k+1 and Ack during cycle k+2; one access per 3 cycles maximum.
REQ-021 Simultaneous Req0 and Req1 in OCIOSO SHALL be granted to the port indicated by the priority pointer (see Configuration).
REQ-022 A requester SHALL hold Req and its inputs until its Ack; a Req still high in the OCIOSO cycle after Ack SHALL count as a new request.
REQ-023 A Req dropped after it is latched SHALL NOT abort the access; the strobe and Ack SHALL still occur.
REQ-024 A Req dropped before it is sampled SHALL cause no memory access.
REQ-025 DadoLido0/1 SHALL hold their last value until the next read completes on that port; writes SHALL NOT modify them.
REQ-026 MenWrite and MenRead SHALL never be high in the same cycle.

Reset
REQ-027 On Reset high at a rising edge: state = OCIOSO; Ack0, Ack1, MenWrite, MenRead and Ocupado = 0; Endereco, DadoEscr, DadoLido0 and DadoLido1 = 0; priority pointer = port 0.
REQ-028 Reset asserted during ACESSO or RESPOSTA SHALL abandon the access: no Ack is issued and the strobe drops at that edge.

Configuration
REQ-029 Macro PRIORIDADE_FIXA_EN defined: port 0 SHALL always win simultaneous requests; the pointer is constant.
REQ-030 Macro PRIORIDADE_FIXA_EN undefined (default): round-robin; after each grant the pointer SHALL move to the non-granted port.

Verification
REQ-031 Req0=1, Escr0=1, Endereco0=0x10, DadoEscr0=0xA5 -> MenWrite=1 with Endereco=0x10 and DadoEscr=0xA5 one cycle later; Ack0 pulses in the cycle after that.
REQ-032 Write 0x3C to 0x20 via port 1, then read 0x20 via port 0 -> MenRead=1, Endereco=0x20; DadoLido0=0x3C while Ack0=1; DadoLido1 unchanged.
REQ-033 Req0 and Req1 held high continuously (round-robin) -> Acks alternate 0,1,0,1 at a 3-cycle spacing; with PRIORIDADE_FIXA_EN, only Ack0 pulses.
REQ-034 Reset pulsed during ACESSO of a port 1 read -> no Ack1; all outputs 0 next cycle; state OCIOSO, then the next simultaneous request goes to port 0.
REQ-035 Over a random request mix of at least 500 accesses -> MenWrite&MenRead never both 1, at most one Ack high per cycle, and each Ack matches a latched request.
